// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator back end: folds MSB-first one-hot per-bit flags
// into a registered word-level gt/eq/lt verdict with an error flag.
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_gt,
    input  logic in_eq,
    input  logic in_lt,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_gt,
    output logic out_eq,
    output logic out_lt,
    output logic out_err
);

    // state | meaning
    // IDLE  | waiting for the first (MSB) beat of a word
    // ACCUM | mid-word, folding further beats into the decision
    // HOLD  | verdict presented, waiting for out_ready
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [2:0] DEC_GT = 3'b100;
    localparam logic [2:0] DEC_EQ = 3'b010;
    localparam logic [2:0] DEC_LT = 3'b001;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      dec;
    logic            err;

    logic [2:0]      flags;
    logic            accept;
    logic            onehot;
    logic [CW-1:0]   count_inc;
    logic            at_width;
    logic            word_end;
    logic            len_err;
    logic [2:0]      dec_nxt;
    logic            err_nxt;

    assign flags     = {in_gt, in_eq, in_lt};
    assign accept    = in_valid && in_ready;
    assign onehot    = (flags == DEC_GT) || (flags == DEC_EQ) || (flags == DEC_LT);
    assign count_inc = count + CW'(1);
    assign at_width  = (count_inc == WIDTH_C);
    assign word_end  = in_last || at_width;
    // Length is wrong whenever in_last and the WIDTH-th beat do not coincide.
    assign len_err   = in_last ^ at_width;
    assign dec_nxt   = (dec == DEC_EQ && onehot && !in_eq) ? flags : dec;
    assign err_nxt   = err || !onehot || len_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            dec       <= DEC_EQ;
            err       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_gt    <= 1'b0;
            out_eq    <= 1'b0;
            out_lt    <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (word_end) begin
                            state                    <= HOLD;
                            in_ready                 <= 1'b0;
                            out_valid                <= 1'b1;
                            {out_gt, out_eq, out_lt} <= dec_nxt;
                            out_err                  <= err_nxt;
                            count                    <= '0;
                            dec                      <= DEC_EQ;
                            err                      <= 1'b0;
                        end else begin
                            state <= ACCUM;
                            count <= count_inc;
                            dec   <= dec_nxt;
                            err   <= err_nxt;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        out_gt    <= 1'b0;
                        out_eq    <= 1'b0;
                        out_lt    <= 1'b0;
                        out_err   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
